operand_fwd_ctrl: RTL and testbench
===================================

# operand_fwd_ctrl

Forwarding and load-use hazard controller for the 8-bit pipelined datapath, sitting directly upstream of the 8-bit 4:1 operand mux in the execute stage. It tracks destination-register state for the EX and MEM stages and computes the mux's 2-bit select for each decoded source operand: register file, EX result, MEM result, or immediate. It also raises a one-cycle stall on load-use hazards and keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- CNT_W, 8, width of the stall performance counter

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- id_valid  input  1  decode stage holds a valid instruction
- id_src  input  3  source register index of the operand being selected; r0 reads as zero
- id_use_imm  input  1  operand is the immediate, not a register
- id_wr  input  1  decode instruction writes a destination register
- id_dst  input  3  destination register index of the decode instruction
- id_is_load  input  1  decode instruction is a memory load
- flush  input  1  squash the decode instruction (taken branch)
- sel  output  2  operand mux select: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = immediate
- stall  output  1  hold the PC and decode stage; insert a bubble into EX
- ex_valid  output  1  EX tracking entry valid (debug/visibility)
- mem_valid  output  1  MEM tracking entry valid (debug/visibility)
- stall_count  output  CNT_W  saturating count of stall cycles since reset

## Operation
- State consists of two tracking entries. EX holds {valid, dst, is_load}. MEM holds {valid, dst}.
- Advance at each rising edge:
  - If flush or stall: EX.valid <= 0 (bubble).
  - Otherwise: EX <= {id_valid & id_wr, id_dst, id_is_load}.
  - MEM <= {EX.valid, EX.dst} on every edge, regardless of stall or flush.
- An entry with dst = 0 never matches a source, because r0 is never forwarded.
- Hazard terms (match requires src != 0):
  - ex_hit = EX.valid & EX.dst == id_src
  - mem_hit = MEM.valid & MEM.dst == id_src
- stall = id_valid & !id_use_imm & ex_hit & EX.is_load. Stall is suppressed while flush = 1, since the squashed instruction cannot create a hazard.
- sel priority, highest first:
  1. id_use_imm -> 3
  2. stall -> 0
  3. ex_hit & !EX.is_load -> 1
  4. mem_hit -> 2
  5. otherwise -> 0
- EX has priority over MEM when both match, because EX holds the younger writer.
- Writeback needs no forwarding: the register file is write-through, so a value written in WB is visible to a read in the same cycle.
- stall_count increments by 1 on each edge where stall = 1. It saturates at 2^CNT_W − 1 and never wraps.
- sel and stall are valid regardless of id_valid. Consumers ignore them when id_valid = 0, except that stall is 0 whenever id_valid = 0.

## Timing
- sel and stall are purely combinational from the id_* inputs and the registered EX/MEM state, with zero-cycle latency. No combinational path exists from the id_* inputs to the registered state within the same cycle.
- A load-use hazard costs exactly one stall cycle. On the next cycle the load has moved to MEM, the held instruction sees mem_hit, and sel = 2.
- Reset (asynchronous, takes effect immediately):
  - EX.valid, MEM.valid = 0; EX.dst, EX.is_load, MEM.dst = 0; stall_count = 0.
  - Hence stall = 0, and sel = 3 if id_use_imm = 1, else 0.
- Reset asserted mid-stall: stall drops at once and both entries are cleared. The first post-reset cycle behaves as an empty pipeline.
- flush and stall in the same cycle: flush wins. EX receives a bubble, MEM advances normally, and stall_count does not increment because stall is suppressed.
- Back-to-back writes to the same register in EX and MEM: sel = 1.

## Test plan
- Reset, then id_valid = 1, id_src = 3 with an empty pipeline -> sel = 0, stall = 0, ex_valid = 0, mem_valid = 0.
- ALU writing r2 (id_wr = 1, id_dst = 2, id_is_load = 0) followed by a consumer with id_src = 2 -> sel = 1 in cycle 1. A consumer in the cycle after that, with a non-writing instruction between, sees sel = 2.
- Load writing r5, then a consumer with id_src = 5 -> stall = 1 and sel = 0 for one cycle, then stall = 0 and sel = 2. stall_count goes from 0 to 1.
- Writers to r4 in both EX and MEM, consumer id_src = 4 -> sel = 1. The same scenario with id_src = 0 -> sel = 0. With id_use_imm = 1 and src matching -> sel = 3.
- Load in EX matching id_src with flush = 1 -> stall = 0 and stall_count unchanged. On the next edge ex_valid = 0 and mem_valid = 1.
- With CNT_W = 2, force 5 load-use stalls -> stall_count reads 3 and holds there. Pulse rst while stall = 1 -> stall_count = 0, stall = 0, and ex_valid and mem_valid drop immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: operand mux select, load-use stall and stall counter for the execute stage
module operand_fwd_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_src,
    input  logic             id_use_imm,
    input  logic             id_wr,
    input  logic [2:0]       id_dst,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       sel,
    output logic             stall,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic [CNT_W-1:0] stall_count
);
    logic             ex_valid_q, ex_valid_d, ex_load_q, ex_load_d, mem_valid_q, mem_valid_d;
    logic [2:0]       ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_hit, mem_hit, bubble;

    // r0 is hardwired to zero, so a zero source never matches a writer
    always_comb begin
        ex_hit      = ex_valid_q && id_src != 3'd0 && ex_dst_q == id_src;
        mem_hit     = mem_valid_q && id_src != 3'd0 && mem_dst_q == id_src;
        stall       = id_valid && !id_use_imm && ex_hit && ex_load_q && !flush;
        sel         = id_use_imm ? 2'd3 : stall ? 2'd0 : (ex_hit && !ex_load_q) ? 2'd1 : mem_hit ? 2'd2 : 2'd0;
        bubble      = flush || stall;
        ex_valid_d  = bubble ? 1'b0 : id_valid && id_wr;
        ex_dst_d    = bubble ? ex_dst_q : id_dst;
        ex_load_d   = bubble ? ex_load_q : id_is_load;
        mem_valid_d = ex_valid_q;
        mem_dst_d   = ex_dst_q;
        cnt_d       = (stall && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_dst_q    <= 3'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dst_q   <= 3'd0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dst_q    <= ex_dst_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_dst_q   <= mem_dst_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign mem_valid   = mem_valid_q;
    assign stall_count = cnt_q;
endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// tb_operand_fwd_ctrl: directed vector table plus saturation and async-reset sequences
module tb_operand_fwd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 0, id_use_imm = 0, id_wr = 0, id_is_load = 0, flush = 0;
    logic [2:0] id_src = 0, id_dst = 0;
    logic [1:0] sel_a, sel_b;
    logic       stall_a, stall_b, exv_a, exv_b, memv_a, memv_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    int         n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    operand_fwd_ctrl u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_use_imm(id_use_imm),
        .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load), .flush(flush),
        .sel(sel_a), .stall(stall_a), .ex_valid(exv_a), .mem_valid(memv_a), .stall_count(cnt_a)
    );

    operand_fwd_ctrl #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_use_imm(id_use_imm),
        .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load), .flush(flush),
        .sel(sel_b), .stall(stall_b), .ex_valid(exv_b), .mem_valid(memv_b), .stall_count(cnt_b)
    );

    typedef struct {
        logic       v;
        logic [2:0] src;
        logic       imm, wr;
        logic [2:0] dst;
        logic       ld, fl;
        logic [1:0] sel;
        logic       st, exv, memv;
        int         cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic v, input int src, input logic imm, input logic wr,
                                input int dst, input logic ld, input logic fl, input int sel,
                                input logic st, input logic exv, input logic memv, input int cnt);
        vec_t r;
        r.v = v; r.src = 3'(src); r.imm = imm; r.wr = wr; r.dst = 3'(dst); r.ld = ld; r.fl = fl;
        r.sel = 2'(sel); r.st = st; r.exv = exv; r.memv = memv; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int src, input logic imm, input logic wr,
                         input int dst, input logic ld, input logic fl);
        @(negedge clk);
        id_valid = v; id_src = 3'(src); id_use_imm = imm; id_wr = wr;
        id_dst = 3'(dst); id_is_load = ld; flush = fl;
        #1;
    endtask

    task automatic chk_both(input string name, input int sel, input int st, input int exv, input int memv);
        chk({name, ".sel"}, int'(sel_a), sel);
        chk({name, ".stall"}, int'(stall_a), st);
        chk({name, ".exv"}, int'(exv_a), exv);
        chk({name, ".memv"}, int'(memv_a), memv);
        chk({name, ".sel2"}, int'(sel_b), sel);
        chk({name, ".stall2"}, int'(stall_b), st);
    endtask

    initial begin
        //              v src imm wr dst ld fl | sel st exv memv cnt
        tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // empty pipeline
        tbl[1]  = mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);  // ALU writes r2
        tbl[2]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);  // EX forward
        tbl[3]  = mk(1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);  // MEM forward
        tbl[4]  = mk(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);  // load r5
        tbl[5]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);  // load-use stall
        tbl[6]  = mk(1, 5, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1);  // held op takes MEM
        tbl[7]  = mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1);  // writer r4
        tbl[8]  = mk(1, 4, 0, 1, 4, 0, 0, 1, 0, 1, 0, 1);  // writer r4 again
        tbl[9]  = mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 1, 1);  // src r0 never forwarded
        tbl[10] = mk(1, 4, 1, 1, 4, 0, 0, 3, 0, 1, 1, 1);  // immediate wins
        tbl[11] = mk(1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);  // EX beats MEM
        tbl[12] = mk(1, 4, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1);
        tbl[13] = mk(1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 1);  // load r6
        tbl[14] = mk(1, 6, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);  // flush suppresses stall
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[16] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);  // load r1
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  // no stall without id_valid
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("rst.exv", int'(exv_a), 0);
        chk("rst.cnt", int'(cnt_a), 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, int'(tbl[i].src), tbl[i].imm, tbl[i].wr, int'(tbl[i].dst), tbl[i].ld, tbl[i].fl);
            chk_both($sformatf("v%0d", i), int'(tbl[i].sel), int'(tbl[i].st), int'(tbl[i].exv), int'(tbl[i].memv));
            chk($sformatf("v%0d.cnt", i), int'(cnt_a), tbl[i].cnt);
            chk($sformatf("v%0d.cnt2", i), int'(cnt_b), tbl[i].cnt > 3 ? 3 : tbl[i].cnt);
        end

        // five more load-use stalls: wide counter reaches 6, narrow one pins at 3
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 1, 5, 1, 0);
            drive(1, 5, 0, 0, 0, 0, 0);
            chk($sformatf("sat%0d.stall", k), int'(stall_a), 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sat.cnt", int'(cnt_a), 6);
        chk("sat.cnt2", int'(cnt_b), 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sat.hold2", int'(cnt_b), 3);

        // async reset while stalled with both entries full
        drive(1, 0, 0, 1, 3, 0, 0);
        drive(1, 0, 0, 1, 5, 1, 0);
        drive(1, 5, 0, 0, 0, 0, 0);
        chk_both("pre_rst", 0, 1, 1, 1);
        rst = 1'b1;
        #1;
        chk_both("mid_rst", 0, 0, 0, 0);
        chk("mid_rst.cnt", int'(cnt_a), 0);
        chk("mid_rst.cnt2", int'(cnt_b), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 5, 0, 0, 0, 0, 0);
        chk_both("post_rst", 0, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 0, 0);
        chk("post_rst.imm", int'(sel_a), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
